// File: rtl/i2c_reg_master.sv
// i2c_reg_master: turns one register read/write request into a complete
// I2C transaction by sequencing the cmd_*/data_* inputs of the bit engine,
// and returns read data plus ACK/timeout status on a response channel.
module i2c_reg_master #(
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_hs,
    input  logic [6:0]  req_dev,
    input  logic [7:0]  req_reg,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  rsp_err,
    output logic        cmd_active,
    output logic        cmd_high_speed,
    output logic [6:0]  cmd_addr,
    output logic        cmd_read,
    input  logic        addr_err,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [7:0]  data_in,
    input  logic [7:0]  data_out,
    input  logic        data_err
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PTR, WDATA, GAP, RDATA, STOP, RESP} state_t;

    state_t           state;
    logic             wr;
    logic [1:0]       len;
    logic [31:0]      wdata;
    logic [1:0]       idx;
    logic [1:0]       idx_nx;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;

    assign idx_nx = idx + 2'd1;

    // Transaction sequencer: phases, byte handshake, error/timeout abort and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= '0;
            cmd_active <= 1'b0;
            cmd_read   <= 1'b0;
            data_valid <= 1'b0;
            data_in    <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr             <= req_write;
                        len            <= req_len;
                        wdata          <= req_wdata;
                        req_ready      <= 1'b0;
                        rsp_err        <= '0;
                        rsp_rdata      <= '0;
                        cmd_active     <= 1'b1;
                        cmd_read       <= 1'b0;
                        cmd_addr       <= req_dev;
                        cmd_high_speed <= req_hs;
                        data_in        <= req_reg;
                        data_valid     <= 1'b1;
                        to_cnt         <= '0;
                        state          <= PTR;
                    end
                end
                PTR: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        if (addr_err || data_err) begin
                            // Register byte rejected: no data phase, close the bus.
                            rsp_err    <= {1'b0, data_err, addr_err};
                            cmd_active <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= STOP;
                        end else if (wr) begin
                            data_in <= wdata[7:0];
                            idx     <= '0;
                            state   <= WDATA;
                        end else begin
                            // Read: STOP after the pointer, repeated transaction follows.
                            cmd_active <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_err[2] <= 1'b1;
                        data_valid <= 1'b0;
                        cmd_active <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= STOP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                WDATA: begin
                    if (!data_valid) begin
                        // One idle cycle after each byte, then offer the next one.
                        data_valid <= 1'b1;
                        to_cnt     <= '0;
                    end else if (data_ready) begin
                        data_valid <= 1'b0;
                        if (data_err || idx == len) begin
                            rsp_err[1] <= data_err;
                            cmd_active <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= STOP;
                        end else begin
                            idx     <= idx_nx;
                            data_in <= wdata[{idx_nx, 3'b000} +: 8];
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_err[2] <= 1'b1;
                        data_valid <= 1'b0;
                        cmd_active <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= STOP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    cmd_read <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        cmd_active <= 1'b1;
                        data_valid <= 1'b1;
                        to_cnt     <= '0;
                        idx        <= '0;
                        state      <= RDATA;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                RDATA: begin
                    if (!data_valid) begin
                        data_valid <= 1'b1;
                        to_cnt     <= '0;
                    end else if (data_ready) begin
                        data_valid <= 1'b0;
                        if (idx == 2'd0 && addr_err) begin
                            // Read address NACKed: the received byte is meaningless.
                            rsp_err[0] <= 1'b1;
                            cmd_active <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= STOP;
                        end else begin
                            rsp_rdata[{idx, 3'b000} +: 8] <= data_out;
                            if (idx == len) begin
                                cmd_active <= 1'b0;
                                gap_cnt    <= '0;
                                state      <= STOP;
                            end else begin
                                idx <= idx_nx;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_err[2] <= 1'b1;
                        data_valid <= 1'b0;
                        cmd_active <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= STOP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                STOP: begin
                    // Give the engine time to put STOP on the bus before responding.
                    if (gap_cnt == GAP_LAST) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed register transactions against a behavioural
// I2C engine model that logs the bus as START+addr / byte / STOP tokens.
module tb_i2c_reg_master;

    localparam int GAP = 4;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_hs;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_err;
    logic        cmd_active;
    logic        cmd_high_speed;
    logic [6:0]  cmd_addr;
    logic        cmd_read;
    logic        addr_err;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_err;

    i2c_reg_master #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_hs(req_hs), .req_dev(req_dev), .req_reg(req_reg),
        .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cmd_active(cmd_active), .cmd_high_speed(cmd_high_speed),
        .cmd_addr(cmd_addr), .cmd_read(cmd_read), .addr_err(addr_err),
        .data_valid(data_valid), .data_ready(data_ready),
        .data_in(data_in), .data_out(data_out), .data_err(data_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine model state
    logic [9:0] trace[$];
    logic [9:0] exp_q[$];
    bit         ready_en = 1'b1;
    bit         nack_addr = 1'b0;
    int         nack_at = -1;
    logic [7:0] rd_bytes[4];
    int         rd_idx = 0;
    int         wr_idx = 0;
    int         wcnt = 0;
    bit         first = 1'b0;
    logic       prev_act = 1'b0;
    logic       prev_rv = 1'b0;
    int         low_run = 0;
    int         last_low_run = 0;
    int         rsp_pulses = 0;

    // Behavioural engine: answers each byte request two cycles after data_valid.
    initial begin
        data_ready = 1'b0;
        addr_err   = 1'b0;
        data_err   = 1'b0;
        data_out   = 8'h00;
        forever begin
            @(negedge clk);
            data_ready = 1'b0;
            addr_err   = 1'b0;
            data_err   = 1'b0;
            if (rsp_valid && !prev_rv) rsp_pulses++;
            prev_rv = rsp_valid;
            if (cmd_active && !prev_act) begin
                trace.push_back(10'h100 | {2'b00, cmd_addr, cmd_read});
                first = 1'b1;
                last_low_run = low_run;
                low_run = 0;
            end
            if (!cmd_active && prev_act) trace.push_back(10'h200);
            if (!cmd_active) low_run++;
            prev_act = cmd_active;
            if (cmd_active && data_valid && ready_en) begin
                wcnt++;
                if (wcnt == 2) begin
                    wcnt = 0;
                    data_ready = 1'b1;
                    addr_err = first && nack_addr;
                    first = 1'b0;
                    if (cmd_read) begin
                        data_out = (rd_idx < 4) ? rd_bytes[rd_idx] : 8'hFF;
                        rd_idx++;
                        if (!addr_err) trace.push_back({2'b00, data_out});
                    end else begin
                        data_err = (wr_idx == nack_at);
                        wr_idx++;
                        if (!addr_err) trace.push_back({2'b00, data_in});
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic start_txn(input logic wr, input logic hs, input logic [6:0] dev,
                             input logic [7:0] rg, input logic [1:0] len, input logic [31:0] wd);
        trace.delete();
        rd_idx = 0;
        wr_idx = 0;
        rsp_pulses = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_hs    = hs;
        req_dev   = dev;
        req_reg   = rg;
        req_len   = len;
        req_wdata = wd;
        @(posedge clk);
        #1 check("req_ready_drop", req_ready, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_valid_clear", rsp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_trace();
        check("trace_len", trace.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
            check("trace_tok", trace[i], exp_q[i]);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_hs = 1'b0; req_dev = '0;
        req_reg = '0; req_len = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cmd_active", cmd_active, 1'b0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_cmd_read", cmd_read, 1'b0);
        check("rst_data_in", data_in, 8'h00);
        check("rst_rsp", {rsp_err, rsp_rdata}, 35'h0);
        @(negedge clk);
        reset = 1'b0;

        // Register read, 4 bytes, high-speed
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
        start_txn(1'b0, 1'b1, 7'h68, 8'h3B, 2'd3, 32'h0);
        wait_rsp("rd_rsp_seen");
        check("rd_rdata", rsp_rdata, 32'h44332211);
        check("rd_err", rsp_err, 3'b000);
        check("rd_hs", cmd_high_speed, 1'b1);
        check("rd_gap_ok", last_low_run >= GAP, 1'b1);
        exp_q = '{10'h1D0, 10'h03B, 10'h200, 10'h1D1, 10'h011, 10'h022, 10'h033, 10'h044, 10'h200};
        check_trace();
        ack_rsp();

        // Register write, 2 bytes; rdata from the previous read must be cleared
        start_txn(1'b1, 1'b0, 7'h50, 8'h10, 2'd1, 32'h0000BEEF);
        wait_rsp("wr_rsp_seen");
        check("wr_err", rsp_err, 3'b000);
        check("wr_rdata", rsp_rdata, 32'h0);
        check("wr_pulses", rsp_pulses, 1);
        exp_q = '{10'h1A0, 10'h010, 10'h0EF, 10'h0BE, 10'h200};
        check_trace();
        ack_rsp();

        // Absent device: address NACK on the register byte
        nack_addr = 1'b1;
        start_txn(1'b1, 1'b0, 7'h21, 8'h05, 2'd1, 32'h0000A5A5);
        wait_rsp("nak_rsp_seen");
        check("nak_err", rsp_err, 3'b001);
        exp_q = '{10'h142, 10'h200};
        check_trace();
        repeat (5) @(negedge clk);
        check("nak_pulses", rsp_pulses, 1);
        ack_rsp();
        nack_addr = 1'b0;

        // Data NACK on the second data byte of a 4-byte write
        nack_at = 2;
        start_txn(1'b1, 1'b0, 7'h50, 8'h20, 2'd3, 32'h44332211);
        wait_rsp("dnak_rsp_seen");
        check("dnak_err", rsp_err, 3'b010);
        exp_q = '{10'h1A0, 10'h020, 10'h011, 10'h022, 10'h200};
        check_trace();
        ack_rsp();
        nack_at = -1;

        // Engine never answers: timeout
        ready_en = 1'b0;
        start_txn(1'b1, 1'b0, 7'h50, 8'h30, 2'd0, 32'h0);
        wait_rsp("tmo_rsp_seen");
        check("tmo_err", rsp_err, 3'b100);
        check("tmo_cmd_active", cmd_active, 1'b0);
        exp_q = '{10'h1A0, 10'h200};
        check_trace();
        ack_rsp();
        ready_en = 1'b1;

        // Reset in the middle of the read data phase
        begin
            bit hit = 1'b0;
            start_txn(1'b0, 1'b0, 7'h68, 8'h3B, 2'd3, 32'h0);
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (cmd_active && cmd_read && data_valid) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("mid_rdata_reached", hit, 1'b1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            check("mrst_req_ready", req_ready, 1'b1);
            check("mrst_cmd_active", cmd_active, 1'b0);
            check("mrst_rsp_valid", rsp_valid, 1'b0);
            check("mrst_data_valid", data_valid, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            rsp_pulses = 0;
            repeat (30) @(negedge clk);
            check("mrst_no_rsp", rsp_pulses, 0);
        end

        // Single-byte write with the response held off
        start_txn(1'b1, 1'b0, 7'h50, 8'h01, 2'd0, 32'h0000005A);
        wait_rsp("hold_rsp_seen");
        repeat (10) @(negedge clk);
        check("hold_rsp_valid", rsp_valid, 1'b1);
        check("hold_rsp", {rsp_err, rsp_rdata}, 35'h0);
        exp_q = '{10'h1A0, 10'h001, 10'h05A, 10'h200};
        check_trace();
        ack_rsp();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
